// File: rtl/uart_tx_fifo.sv
// Self-timed UART transmitter (8N1, or 8E1 with UART_TX_PARITY_EN) fed by an internal byte FIFO.
// Latency: byte pushed into an empty idle FIFO drives the start bit two clocks later; frames run back-to-back.
// Backpressure: wr_ready_o drops only when the registered FIFO count is full; a same-cycle pop does not help.
module uart_tx_fifo #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD_RATE      = 9600,
    parameter int BAUD_COUNT_MAX = CLK_FREQ / BAUD_RATE,
    parameter int BAUD_BITS      = 14,
    parameter int FIFO_DEPTH     = 16,
    parameter int PTR_BITS       = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [7:0]          wr_data_i,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    output logic                txd_o,
    output logic                busy_o,
    output logic [PTR_BITS:0]   fifo_count_o
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [BAUD_BITS-1:0] BAUD_LAST  = BAUD_BITS'(BAUD_COUNT_MAX - 1);
    localparam logic [PTR_BITS:0]    COUNT_FULL = (PTR_BITS+1)'(FIFO_DEPTH);

    state_t               state_q, state_d;
    logic [BAUD_BITS-1:0] baud_q, baud_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [PTR_BITS-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_BITS:0]    count_q, count_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [7:0]           head;
    logic                 push, pop, bit_end;

    assign wr_ready_o   = (count_q != COUNT_FULL);
    assign push         = wr_valid_i & wr_ready_o;
    assign bit_end      = (baud_q == BAUD_LAST);
    assign head         = mem_q[rd_ptr_q];
    assign count_d      = count_q + {{PTR_BITS{1'b0}}, push} - {{PTR_BITS{1'b0}}, pop};
    assign busy_d       = (state_q != S_IDLE) | (count_q != '0);
    assign txd_o        = txd_q;
    assign busy_o       = busy_q;
    assign fifo_count_o = count_q;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        pop       = 1'b0;
        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_BITS'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    // Reload straight from the FIFO so queued frames have no idle gap.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            baud_d   = '0;
            shift_d  = head;
            parity_d = ^head;
        end
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_q[0];
            S_PARITY: txd_d = parity_q;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            count_q   <= count_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
        end
    end
endmodule
